// File: rtl/instr_seq_pkg.sv
// Shared constants and the state type for the instruction sequencer.
package instr_seq_pkg;
  localparam int unsigned DATA_W = 20;
  localparam int unsigned DEPTH  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/seq_mem.sv
// Program buffer: register array with one synchronous write port and one
// asynchronous read port. Storage is deliberately not reset.
module seq_mem #(
  parameter int unsigned DEPTH  = instr_seq_pkg::DEPTH,
  parameter int unsigned DATA_W = instr_seq_pkg::DATA_W,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// Buffers a program written over a valid/ready port and replays it to the
// core one word per clock. Define SEQ_LOOP_EN to replay the program
// continuously until stop instead of a single pass.
module instr_sequencer #(
  parameter int unsigned DEPTH  = instr_seq_pkg::DEPTH,
  parameter int unsigned DATA_W = instr_seq_pkg::DATA_W,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              pad_clk,
  input  logic              pad_rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   level
);
  import instr_seq_pkg::*;

  localparam int unsigned LVL_W = ADDR_W + 1;

  state_t            state, state_nx;
  logic [LVL_W-1:0]  level_nx;
  logic [LVL_W-1:0]  rd_ptr, rd_ptr_nx;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] instr_out_nx;
  logic              instr_valid_nx;
  logic              done_nx;
  logic              wr_en;

  // rd_ptr is one bit wider than the array so a full buffer can be compared
  // against level; any index past the end (start or wrap) reads entry 0.
  assign rd_addr = (state == RUN && rd_ptr != level) ? rd_ptr[ADDR_W-1:0] : '0;

  assign wr_ready = (state == IDLE) && !start && !clear && (level < LVL_W'(DEPTH));

  seq_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (pad_clk),
    .we    (wr_en),
    .waddr (level[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_nx       = state;
    level_nx       = level;
    rd_ptr_nx      = rd_ptr;
    instr_out_nx   = '0;
    instr_valid_nx = 1'b0;
    done_nx        = 1'b0;
    wr_en          = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          level_nx = '0;
        end else if (start && level != '0) begin
          state_nx       = RUN;
          instr_out_nx   = rd_data;
          instr_valid_nx = 1'b1;
          rd_ptr_nx      = LVL_W'(1);
        end else if (wr_valid && wr_ready) begin
          wr_en    = 1'b1;
          level_nx = level + LVL_W'(1);
        end
      end
      RUN: begin
        if (stop) begin
          state_nx  = IDLE;
          done_nx   = 1'b1;
          rd_ptr_nx = '0;
        end else if (rd_ptr == level) begin
`ifdef SEQ_LOOP_EN
          instr_out_nx   = rd_data;
          instr_valid_nx = 1'b1;
          rd_ptr_nx      = LVL_W'(1);
`else
          state_nx  = IDLE;
          done_nx   = 1'b1;
          rd_ptr_nx = '0;
`endif
        end else begin
          instr_out_nx   = rd_data;
          instr_valid_nx = 1'b1;
          rd_ptr_nx      = rd_ptr + LVL_W'(1);
        end
      end
      default: begin
        state_nx  = IDLE;
        rd_ptr_nx = '0;
      end
    endcase
  end

  always_ff @(posedge pad_clk or negedge pad_rst_n) begin
    if (!pad_rst_n) begin
      state       <= IDLE;
      level       <= '0;
      rd_ptr      <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      level       <= level_nx;
      rd_ptr      <= rd_ptr_nx;
      instr_out   <= instr_out_nx;
      instr_valid <= instr_valid_nx;
      busy        <= (state_nx == RUN);
      done        <= done_nx;
    end
  end
endmodule
